// File: rtl/layer_neuron_sequencer.sv
// Steps a time-multiplexed dot-product PE over a layer and packs requantized results.
// Define LAYER_NEURON_SEQ_RELU_EN to apply ReLU between shift and saturation.
module layer_neuron_sequencer #(
    parameter int NUM_NEURONS = 16,
    parameter int W           = 8,
    parameter int ACC_WIDTH   = W + 7,
    parameter int SHIFT       = 4,
    parameter int IDX_W       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     layer_start,
    output logic                     busy,
    output logic [IDX_W-1:0]         neuron_idx,
    output logic                     pe_start,
    input  logic [ACC_WIDTH-1:0]     pe_result,
    input  logic                     pe_done,
    output logic [W*NUM_NEURONS-1:0] out_vector_flat,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_STORE,
        S_OUT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((1 << (W - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_t state;
    state_t state_n;

    logic [IDX_W-1:0]            idx_n;
    logic                        cap_en;
    logic                        store_en;
    logic signed [ACC_WIDTH-1:0] captured;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] activ;
    logic signed [W-1:0]         q_val;

    // Requantize the captured accumulator: shift, optional ReLU, saturate.
    always_comb begin
        shifted = captured >>> SHIFT;
`ifdef LAYER_NEURON_SEQ_RELU_EN
        activ = shifted[ACC_WIDTH-1] ? '0 : shifted;
`else
        activ = shifted;
`endif
        if (activ > SAT_MAX) begin
            q_val = SAT_MAX[W-1:0];
        end else if (activ < SAT_MIN) begin
            q_val = SAT_MIN[W-1:0];
        end else begin
            q_val = activ[W-1:0];
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = neuron_idx;
        cap_en   = 1'b0;
        store_en = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (layer_start) begin
                    state_n = S_START;
                    idx_n   = '0;
                end
            end
            S_START: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (pe_done) begin
                    cap_en  = 1'b1;
                    state_n = S_STORE;
                end
            end
            S_STORE: begin
                store_en = 1'b1;
                if (neuron_idx == LAST_IDX) begin
                    state_n = S_OUT;
                end else begin
                    idx_n   = neuron_idx + IDX_W'(1);
                    state_n = S_START;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            neuron_idx <= '0;
        end else begin
            state      <= state_n;
            neuron_idx <= idx_n;
        end
    end

    // Slots not yet rewritten keep the previous layer's value.
    always_ff @(posedge clk) begin
        if (reset) begin
            captured        <= '0;
            out_vector_flat <= '0;
        end else begin
            if (cap_en) begin
                captured <= pe_result;
            end
            if (store_en) begin
                out_vector_flat[int'(neuron_idx)*W +: W] <= q_val;
            end
        end
    end

    assign pe_start  = (state == S_START);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_OUT);

endmodule

// File: tb/tb_layer_neuron_sequencer.sv
// Self-checking bench for layer_neuron_sequencer with a behavioural PE and requant model.
module tb_layer_neuron_sequencer;

    localparam int NN = 4;
    localparam int W  = 8;
    localparam int AW = 15;
    localparam int SH = 2;
    localparam int IW = 2;
    localparam int VL = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              layer_start;
    logic              busy;
    logic [IW-1:0]     neuron_idx;
    logic              pe_start;
    logic [AW-1:0]     pe_result;
    logic              pe_done;
    logic [W*NN-1:0]   out_vector_flat;
    logic              out_valid;
    logic              out_ready;

    always #5 clk = ~clk;

    layer_neuron_sequencer #(
        .NUM_NEURONS(NN),
        .W(W),
        .ACC_WIDTH(AW),
        .SHIFT(SH),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .layer_start(layer_start),
        .busy(busy),
        .neuron_idx(neuron_idx),
        .pe_start(pe_start),
        .pe_result(pe_result),
        .pe_done(pe_done),
        .out_vector_flat(out_vector_flat),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int pe_vals[NN];
    int pe_cnt;
    int errors = 0;
    int checks = 0;
    int starts[$];
    int valid_cycles;
    logic [W*NN-1:0] model_vec;

    // Behavioural PE: done rises VL cycles after the start edge, cleared by start.
    always @(posedge clk) begin
        if (reset) begin
            pe_done   <= 1'b0;
            pe_cnt    <= 0;
            pe_result <= '0;
        end else if (pe_start) begin
            pe_done   <= 1'b0;
            pe_cnt    <= VL;
            pe_result <= AW'(pe_vals[neuron_idx]);
        end else if (pe_cnt != 0) begin
            pe_cnt <= pe_cnt - 1;
            if (pe_cnt == 1) pe_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (pe_start) starts.push_back(int'(neuron_idx));
            if (out_valid) valid_cycles = valid_cycles + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int qref(input int x);
        int d;
        int s;
        int hi;
        d = 1 << SH;
        s = x / d;
        if ((x % d != 0) && (x < 0)) s = s - 1;
`ifdef LAYER_NEURON_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        hi = (1 << (W - 1)) - 1;
        if (s > hi) s = hi;
        if (s < -hi - 1) s = -hi - 1;
        return s;
    endfunction

    function automatic int elem(input logic [W*NN-1:0] v, input int k);
        logic signed [W-1:0] e;
        e = v[k*W +: W];
        return int'(e);
    endfunction

    task automatic run_layer(input int v[NN], input int e[NN], input int hold,
                             input bit inject, input bit both, input string tag);
        int cyc;
        bit injected;
        bit stable_ok;
        logic [W*NN-1:0] snap;
        injected = 1'b0;
        for (int k = 0; k < NN; k++) pe_vals[k] = v[k];
        starts.delete();
        valid_cycles = 0;
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 1000) begin
            if (inject && !injected && starts.size() == 2 &&
                busy && !pe_start && !pe_done) begin
                for (int k = 2; k < NN; k++)
                    chk($sformatf("%s old slot %0d", tag, k),
                        elem(out_vector_flat, k), elem(model_vec, k));
                layer_start = 1'b1;
                @(negedge clk);
                layer_start = 1'b0;
                injected = 1'b1;
            end else begin
                @(negedge clk);
            end
            cyc++;
        end
        chk($sformatf("%s out_valid reached", tag), int'(out_valid), 1);
        if (inject) chk($sformatf("%s injected", tag), int'(injected), 1);
        snap = out_vector_flat;
        stable_ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!out_valid || !busy || out_vector_flat !== snap) stable_ok = 1'b0;
        end
        if (hold > 0) chk($sformatf("%s backpressure hold", tag), int'(stable_ok), 1);
        out_ready = 1'b1;
        if (both) layer_start = 1'b1;
        @(negedge clk);
        out_ready   = 1'b0;
        layer_start = 1'b0;
        chk($sformatf("%s out_valid after accept", tag), int'(out_valid), 0);
        chk($sformatf("%s busy after accept", tag), int'(busy), 0);
        for (int k = 0; k < NN; k++) begin
            chk($sformatf("%s elem %0d", tag, k), elem(out_vector_flat, k), e[k]);
            model_vec[k*W +: W] = W'(e[k]);
        end
        chk($sformatf("%s start count", tag), starts.size(), NN);
        for (int k = 0; k < NN; k++)
            chk($sformatf("%s start idx %0d", tag, k),
                (k < starts.size()) ? starts[k] : -1, k);
        chk($sformatf("%s valid cycles", tag), valid_cycles, hold + 1);
        if (inject || both) begin
            repeat (5) @(negedge clk);
            chk($sformatf("%s stays idle", tag), int'(busy), 0);
            chk($sformatf("%s no extra start", tag), starts.size(), NN);
        end
    endtask

    typedef struct {
        int res[NN];
        int exp[NN];
        int hold;
        bit inject;
        bit both;
    } vec_t;

    vec_t tab[4];

    initial begin
        int rv[NN];
        int re[NN];
        int cyc;
        bit flag;

        tab[0] = '{'{100, 1000, 3, 508}, '{25, 127, 0, 127}, 0, 1'b0, 1'b0};
`ifdef LAYER_NEURON_SEQ_RELU_EN
        tab[1] = '{'{-40, -1000, -1, 64}, '{0, 0, 0, 16}, 10, 1'b0, 1'b0};
        tab[2] = '{'{511, 512, -512, -513}, '{127, 127, 0, 0}, 2, 1'b1, 1'b0};
        tab[3] = '{'{16383, -16384, 7, -5}, '{127, 0, 1, 0}, 1, 1'b0, 1'b1};
`else
        tab[1] = '{'{-40, -1000, -1, 64}, '{-10, -128, -1, 16}, 10, 1'b0, 1'b0};
        tab[2] = '{'{511, 512, -512, -513}, '{127, 127, -128, -128}, 2, 1'b1, 1'b0};
        tab[3] = '{'{16383, -16384, 7, -5}, '{127, -128, 1, -2}, 1, 1'b0, 1'b1};
`endif

        reset       = 1'b1;
        layer_start = 1'b0;
        out_ready   = 1'b0;
        for (int k = 0; k < NN; k++) pe_vals[k] = 0;
        model_vec = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        starts.delete();
        valid_cycles = 0;
        flag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || out_valid || pe_start) flag = 1'b1;
        end
        chk("idle outputs quiet", int'(flag), 0);
        chk("idle vector zero", int'(out_vector_flat == '0), 1);
        chk("idle no start", starts.size(), 0);
        chk("idle neuron_idx", int'(neuron_idx), 0);

        for (int i = 0; i < 4; i++)
            run_layer(tab[i].res, tab[i].exp, tab[i].hold,
                      tab[i].inject, tab[i].both, $sformatf("tab%0d", i));

        // Abort in WAIT of neuron 2, then a clean layer from neuron 0.
        for (int k = 0; k < NN; k++) pe_vals[k] = 1234;
        starts.delete();
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        cyc = 0;
        while (!(starts.size() == 3 && !pe_start && !pe_done) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort reached wait2", int'(cyc < 1000), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort busy", int'(busy), 0);
        chk("abort pe_start", int'(pe_start), 0);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort neuron_idx", int'(neuron_idx), 0);
        chk("abort vector zero", int'(out_vector_flat == '0), 1);
        reset = 1'b0;
        model_vec = '0;
        run_layer(tab[0].res, tab[0].exp, 0, 1'b0, 1'b0, "post-abort");

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NN; k++) begin
                rv[k] = int'($urandom_range(0, 32767)) - 16384;
                re[k] = qref(rv[k]);
            end
            run_layer(rv, re, int'($urandom_range(0, 3)), 1'b0, 1'b0,
                      $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_neuron_sequencer.md
Name: layer_neuron_sequencer

Overview:
- Downstream/control stage for the sequential dot-product PE (one PE per layer, time-multiplexed over neurons).
- Steps neuron_idx over NUM_NEURONS rows, pulses PE start, waits for PE done, captures each signed accumulator result and requantizes it.
- Requantization: arithmetic shift, activation, saturate to W bits. Results are packed into a flat W*NUM_NEURONS vector, the format the next layer's PE consumes as its input vector.
- Presents the packed vector with a valid/ready handshake.

Parameters:
- NUM_NEURONS, 16: neurons (weight rows) in the layer.
- W, 8: output element width, signed.
- ACC_WIDTH, W+7: width of PE result.
- SHIFT, 4: arithmetic right shift applied to PE result before saturation; range 0..ACC_WIDTH-1.
- IDX_W, 4: neuron_idx width; must satisfy 2^IDX_W >= NUM_NEURONS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- layer_start  in  1  one-cycle request to process a layer; ignored unless in IDLE.
- busy  out  1  high in every state except IDLE.
- neuron_idx  out  IDX_W  current row; drives external weight-row/bias muxes feeding the PE.
- pe_start  out  1  one-cycle start pulse to PE.
- pe_result  in  ACC_WIDTH  signed PE result.
- pe_done  in  1  PE done level; cleared by PE on the edge that samples pe_start.
- out_vector_flat  out  W*NUM_NEURONS  packed signed outputs; element k at bits [k*W +: W].
- out_valid  out  1  packed vector complete.
- out_ready  in  1  consumer accepts vector.

Behaviour:
- Reset (synchronous, active-high, clk; also mid-operation):
  - State goes to IDLE.
  - neuron_idx=0, pe_start=0, busy=0, out_valid=0, out_vector_flat=0.
  - The PE shares the same reset.
- FSM states: IDLE, START, WAIT, STORE, OUT.
- IDLE:
  - On layer_start=1, go to START and set neuron_idx=0.
  - out_vector_flat keeps its previous contents.
- START:
  - pe_start=1 for exactly this cycle, then go to WAIT.
  - pe_start is 0 in all other states.
- WAIT:
  - Hold neuron_idx stable.
  - When pe_done=1, capture pe_result into an internal register and go to STORE.
  - pe_done in the first WAIT cycle is already 0, because the PE clears it on the START edge; no guard cycle.
- STORE:
  - Write q(captured) into slot neuron_idx.
  - If neuron_idx==NUM_NEURONS-1, go to OUT; otherwise increment neuron_idx and go to START.
- OUT:
  - out_valid=1; out_vector_flat is stable.
  - When out_ready=1 on the same cycle, clear out_valid next cycle and go to IDLE.
  - out_ready while not in OUT is ignored.
  - neuron_idx holds NUM_NEURONS-1 until the next layer.
- Per-neuron cost: 1 (START) + PE latency (VECTOR_LENGTH cycles until done visible, plus the WAIT capture cycle) + 1 (STORE).
- Requantization q(x):
  - s = x >>> SHIFT (sign preserved).
  - Activation per Optional Feature.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - No rounding; truncation toward -inf.
- Slots not yet written in the current layer keep the previous layer's values until overwritten.
- The only way to abort is reset; layer_start in a non-IDLE state is dropped, with no queueing.
- layer_start and out_ready both high in OUT: the handshake completes and the FSM returns to IDLE; that layer_start is dropped.

Optional Feature:
- Macro: LAYER_NEURON_SEQ_RELU_EN.
- Defined: ReLU after shift, so s<0 becomes 0 and the output range is [0, 2^(W-1)-1].
- Undefined: no activation; signed saturation over the full [-2^(W-1), 2^(W-1)-1].

Test Plan (NUM_NEURONS=4, W=8, ACC_WIDTH=15, SHIFT=2, PE with VECTOR_LENGTH=4):
- Reset then idle: no layer_start for 20 cycles -> busy=0, pe_start never 1, out_valid=0, out_vector_flat=0.
- PE results {100, 1000, 3, 508} for neurons 0..3, out_ready=1 -> out_vector_flat elements {25, 127, 0, 127}; exactly 4 pe_start pulses with neuron_idx 0,1,2,3; out_valid high 1 cycle.
- PE results {-40, -1000, -1, 64}:
  - With RELU_EN -> {0, 0, 0, 16}.
  - Without RELU_EN -> {-10, -128, -1, 16}.
- Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid stays 1, vector stable, busy=1; out_ready=1 -> out_valid=0 and IDLE next cycle.
- layer_start pulsed during WAIT of neuron 1 -> ignored: neuron sequence unchanged, single out_valid.
- Reset asserted in WAIT of neuron 2 -> next cycle IDLE with all outputs 0; subsequent layer_start runs a full clean layer from neuron_idx=0.
